// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the second-generation multicycle MIPS controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRtypeEx, StRtypeWb,
    StBeqEx, StBneEx, StImmEx, StImmWb, StJEx, StJalEx, StTrap
  } state_e;

  typedef enum logic [1:0] {AluOpAdd, AluOpSub, AluOpFunct, AluOpImm} aluop_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [2:0] SrcbB     = 3'b000;
  localparam logic [2:0] SrcbFour  = 3'b001;
  localparam logic [2:0] SrcbImm   = 3'b010;
  localparam logic [2:0] SrcbImmSh = 3'b011;
  localparam logic [2:0] SrcbZimm  = 3'b100;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] MtrAluOut = 2'b00;
  localparam logic [1:0] MtrData   = 2'b01;
  localparam logic [1:0] MtrPc     = 2'b10;

  localparam logic [1:0] RdRt  = 2'b00;
  localparam logic [1:0] RdRd  = 2'b01;
  localparam logic [1:0] RdR31 = 2'b10;

  // Logical immediates use the zero-extended operand.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri);
  endfunction

endpackage

// File: rtl/mc_aludec_v2.sv
// ALU decoder: maps aluop/funct/op to an alucontrol code and flags legal R-type functs.
module mc_aludec_v2
  import mc_ctrl_pkg::*;
(
  input  aluop_e     i_aluop,
  input  logic [5:0] i_funct,
  input  logic [5:0] i_op,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_legal
);

  logic [2:0] w_funct_ctl;
  logic [2:0] w_imm_ctl;

  always_comb begin
    o_funct_legal = 1'b1;
    case (i_funct)
      FnAdd:   w_funct_ctl = AluAdd;
      FnSub:   w_funct_ctl = AluSub;
      FnAnd:   w_funct_ctl = AluAnd;
      FnOr:    w_funct_ctl = AluOr;
      FnSlt:   w_funct_ctl = AluSlt;
      default: begin
        w_funct_ctl   = AluAdd;
        o_funct_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (i_op)
      OpAndi:  w_imm_ctl = AluAnd;
      OpOri:   w_imm_ctl = AluOr;
      OpSlti:  w_imm_ctl = AluSlt;
      default: w_imm_ctl = AluAdd;
    endcase
  end

  always_comb begin
    unique case (i_aluop)
      AluOpAdd:   o_alucontrol = AluAdd;
      AluOpSub:   o_alucontrol = AluSub;
      AluOpFunct: o_alucontrol = w_funct_ctl;
      AluOpImm:   o_alucontrol = w_imm_ctl;
      default:    o_alucontrol = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller_v2.sv
// Multicycle MIPS control unit with memory handshake timeout and sticky trap.
// Optional performance counters are enabled by defining MC_CONTROLLER_V2_PERF_EN.
module mc_controller_v2
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 8
`ifdef MC_CONTROLLER_V2_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       memwrite,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic [1:0] memtoreg,
  output logic [1:0] regdst,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       trap
`ifdef MC_CONTROLLER_V2_PERF_EN
  ,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam logic [7:0] WaitLim = 8'(WAIT_LIMIT);

  state_e     r_state, w_state_d;
  logic [7:0] r_wait, w_wait_d, w_wait_inc;
  logic       w_mem_state;
  aluop_e     w_aluop;
  logic       w_alu_en;
  logic [2:0] w_aluc;
  logic       w_funct_legal;

  mc_aludec_v2 u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .i_op         (op),
    .o_alucontrol (w_aluc),
    .o_funct_legal(w_funct_legal)
  );

  assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_wait_inc  = r_wait + 8'd1;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StFetch:  if (mem_ready) w_state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw:                     w_state_d = StMemAdr;
          OpRtype:                        w_state_d = w_funct_legal ? StRtypeEx : StTrap;
          OpBeq:                          w_state_d = StBeqEx;
          OpBne:                          w_state_d = StBneEx;
          OpAddi, OpAndi, OpOri, OpSlti:  w_state_d = StImmEx;
          OpJ:                            w_state_d = StJEx;
          OpJal:                          w_state_d = StJalEx;
          default:                        w_state_d = StTrap;
        endcase
      end
      StMemAdr:  w_state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) w_state_d = StMemWb;
      StMemWr:   if (mem_ready) w_state_d = StFetch;
      StRtypeEx: w_state_d = StRtypeWb;
      StImmEx:   w_state_d = StImmWb;
      StMemWb, StRtypeWb, StImmWb, StBeqEx, StBneEx, StJEx, StJalEx: w_state_d = StFetch;
      StTrap:    w_state_d = StTrap;
      default:   w_state_d = StTrap;
    endcase
    // A completing access in the limit cycle wins over the timeout.
    if (w_mem_state && !mem_ready && (w_wait_inc == WaitLim)) w_state_d = StTrap;
  end

  always_comb begin
    if (!w_mem_state || mem_ready || (w_state_d != r_state)) w_wait_d = 8'd0;
    else w_wait_d = w_wait_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StFetch;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_wait  <= w_wait_d;
    end
  end

  always_comb begin
    memreq   = 1'b0;
    memwrite = 1'b0;
    pcen     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = MtrAluOut;
    regdst   = RdRt;
    alusrcb  = SrcbB;
    pcsrc    = PcAlu;
    trap     = 1'b0;
    w_aluop  = AluOpAdd;
    w_alu_en = 1'b0;
    case (r_state)
      StFetch: begin
        memreq   = 1'b1;
        alusrcb  = SrcbFour;
        w_alu_en = 1'b1;
        irwrite  = mem_ready;
        pcen     = mem_ready;
      end
      StDecode: begin
        alusrcb  = SrcbImmSh;
        w_alu_en = 1'b1;
      end
      StMemAdr: begin
        alusrca  = 1'b1;
        alusrcb  = SrcbImm;
        w_alu_en = 1'b1;
      end
      StMemRd: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = MtrData;
      end
      StMemWr: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StRtypeEx: begin
        alusrca  = 1'b1;
        w_aluop  = AluOpFunct;
        w_alu_en = 1'b1;
      end
      StRtypeWb: begin
        regwrite = 1'b1;
        regdst   = RdRd;
      end
      StBeqEx, StBneEx: begin
        alusrca  = 1'b1;
        w_aluop  = AluOpSub;
        w_alu_en = 1'b1;
        pcsrc    = PcAluOut;
        pcen     = (r_state == StBeqEx) ? zero : ~zero;
      end
      StImmEx: begin
        alusrca  = 1'b1;
        alusrcb  = is_zext_op(op) ? SrcbZimm : SrcbImm;
        w_aluop  = AluOpImm;
        w_alu_en = 1'b1;
      end
      StImmWb: regwrite = 1'b1;
      StJEx: begin
        pcen  = 1'b1;
        pcsrc = PcJump;
      end
      StJalEx: begin
        pcen     = 1'b1;
        pcsrc    = PcJump;
        regwrite = 1'b1;
        regdst   = RdR31;
        memtoreg = MtrPc;
      end
      StTrap:  trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

  assign alucontrol = w_alu_en ? w_aluc : 3'b000;

`ifdef MC_CONTROLLER_V2_PERF_EN
  logic [CNT_W-1:0] r_cycles, r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles  <= '0;
      r_retired <= '0;
    end else if (r_state != StTrap) begin
      r_cycles <= r_cycles + 1'b1;
      if ((r_state != StFetch) && (w_state_d == StFetch)) r_retired <= r_retired + 1'b1;
    end
  end

  assign cycles  = r_cycles;
  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_mc_controller_v2.sv
// Self-checking bench for mc_controller_v2: directed scenarios plus randomized instruction mix.
module tb_mc_controller_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord, trap;
  logic [1:0] memtoreg, regdst, pcsrc;
  logic [2:0] alusrcb, alucontrol;
  logic [19:0] w_outs;
  int checks = 0;
  int errors = 0;
`ifdef MC_CONTROLLER_V2_PERF_EN
  logic [31:0] retired, cycles;
  int e_cycles = 0;
  int e_retired = 0;
`endif

  always #5 clk = ~clk;

  mc_controller_v2 #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memreq    (memreq),
    .memwrite  (memwrite),
    .pcen      (pcen),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .iord      (iord),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .alucontrol(alucontrol),
    .trap      (trap)
`ifdef MC_CONTROLLER_V2_PERF_EN
    ,
    .retired   (retired),
    .cycles    (cycles)
`endif
  );

  assign w_outs = {memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                   alusrcb, pcsrc, alucontrol, trap};

  function automatic logic [19:0] v(input logic mr, input logic mw, input logic pe, input logic ir,
                                    input logic rw, input logic sa, input logic io,
                                    input logic [1:0] mtr, input logic [1:0] rd,
                                    input logic [2:0] sb, input logic [1:0] ps,
                                    input logic [2:0] ac, input logic tr);
    return {mr, mw, pe, ir, rw, sa, io, mtr, rd, sb, ps, ac, tr};
  endfunction

  localparam logic [19:0] TrapV = 20'h00001;

  function automatic logic [19:0] fetch_v(input logic r);
    return v(1, 0, r, r, 0, 0, 0, 2'b00, 2'b00, 3'b001, 2'b00, 3'b010, 0);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000)
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return o inside {6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
                     6'b001101, 6'b001010, 6'b000010, 6'b000011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s op=%b got=%h exp=%h", tag, op, got, exp);
    end
  endtask

  // Called just after a rising edge: drive mem_ready, check mid-cycle, advance one clock.
  task automatic cyc(input logic rdy, input logic [19:0] exp, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, {12'd0, w_outs}, {12'd0, exp});
`ifdef MC_CONTROLLER_V2_PERF_EN
    chk({tag, "_cyc"}, cycles, e_cycles);
    chk({tag, "_ret"}, retired, e_retired);
    if (!exp[0]) e_cycles++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset", {12'd0, w_outs}, {12'd0, fetch_v(0)});
`ifdef MC_CONTROLLER_V2_PERF_EN
    e_cycles = 0;
    e_retired = 0;
    chk("rst_cycles", cycles, 0);
    chk("rst_retired", retired, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    logic [19:0] e;
    op = o;
    funct = f;
    zero = z;
    for (int i = 0; i <= fw; i++) cyc(i == fw, fetch_v(i == fw), "fetch");
    cyc(1'($urandom_range(0, 1)), v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b011, 2'b00, 3'b010, 0),
        "decode");
    if (!legal(o, f)) begin
      for (int i = 0; i < 4; i++) cyc(1'($urandom_range(0, 1)), TrapV, "trap_hold");
      do_reset();
      return;
    end
    case (o)
      6'b100011, 6'b101011: begin
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 2'b00, 3'b010, 0), "memadr");
        e = (o == 6'b101011) ? v(1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0)
                             : v(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0);
        for (int i = 0; i <= mw; i++) cyc(i == mw, e, "memacc");
        if (o == 6'b100011)
          cyc(1'($urandom_range(0, 1)),
              v(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 0), "memwb");
      end
      6'b000000: begin
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, funct_alu(f), 0), "rtypeex");
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b000, 2'b00, 3'b000, 0), "rtypewb");
      end
      6'b000100, 6'b000101:
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, (o == 6'b000100) ? z : !z, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b110,
              0), "branch");
      6'b000010:
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000, 0), "jex");
      6'b000011:
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 1, 0, 1, 0, 0, 2'b10, 2'b10, 3'b000, 2'b10, 3'b000, 0), "jalex");
      default: begin
        e = v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 2'b00, 3'b010, 0);
        if (o == 6'b001100) e = v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b100, 2'b00, 3'b000, 0);
        if (o == 6'b001101) e = v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b100, 2'b00, 3'b001, 0);
        if (o == 6'b001010) e = v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 2'b00, 3'b111, 0);
        cyc(1'($urandom_range(0, 1)), e, "immex");
        cyc(1'($urandom_range(0, 1)),
            v(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "immwb");
      end
    endcase
`ifdef MC_CONTROLLER_V2_PERF_EN
    e_retired++;
`endif
  endtask

  logic [5:0] ops [11];
  logic [5:0] fns [5];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
            6'b001101, 6'b001010, 6'b000010, 6'b000011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b0;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    #3;
    chk("reset_state", {12'd0, w_outs}, {12'd0, fetch_v(0)});
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'b100011, 6'b0, 1'b0, 3, 3);
    run_instr(6'b000101, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b0, 1'b1, 1, 0);
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000100, 6'b0, 1'b1, 2, 0);
    run_instr(6'b001101, 6'b0, 1'b0, 0, 0);
    run_instr(6'b001010, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000011, 6'b0, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b0, 1'b0, 1, 3);

    // Reset asserted while MEMRD waits on memory.
    op = 6'b100011;
    cyc(1'b1, fetch_v(1), "pre_fetch");
    cyc(1'b0, v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b011, 2'b00, 3'b010, 0), "pre_decode");
    cyc(1'b0, v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 2'b00, 3'b010, 0), "pre_memadr");
    cyc(1'b0, v(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "pre_memrd");
    do_reset();

    // Fetch timeout: four idle cycles reach the limit.
    for (int i = 0; i < 4; i++) cyc(1'b0, fetch_v(0), "timeout_fetch");
    for (int i = 0; i < 3; i++) cyc(1'($urandom_range(0, 1)), TrapV, "timeout_trap");
    do_reset();

    // Ready on the limit cycle completes normally.
    run_instr(6'b000010, 6'b0, 1'b0, 3, 0);
    run_instr(6'b100011, 6'b0, 1'b0, 0, 3);

    run_instr(6'b111111, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000111, 1'b0, 1, 0);

    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 10)], fns[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
Second-generation multicycle MIPS control unit. It drives the same multicycle datapath (PC, IR, register file, ALU, muxes) as the current controller, and adds:
- a variable-latency memory handshake with a timeout;
- extra opcodes: BNE, ANDI, ORI, SLTI, JAL;
- a sticky illegal-instruction/timeout trap.

Parameters:
- WAIT_LIMIT, 8: max cycles in any memory state without mem_ready before trap; legal range 1..255.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- memreq  out  1  memory access request
- memwrite  out  1  write strobe, valid with memreq
- pcen  out  1  PC register enable
- irwrite  out  1  IR load
- regwrite  out  1  register-file write
- alusrca  out  1  0=PC, 1=A
- iord  out  1  0=PC, 1=ALUOut address
- memtoreg  out  2  00=ALUOut, 01=Data, 10=PC (JAL link)
- regdst  out  2  00=rt, 01=rd, 10=r31
- alusrcb  out  3  000=B, 001=4, 010=SignImm, 011=SignImm<<2, 100=ZeroImm
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- trap  out  1  sticky fault indication
- retired  out  CNT_W  instructions completed (optional feature only)
- cycles  out  CNT_W  clocks since reset (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, wait counter=0, trap=0, counters=0. All outputs are combinational from state; the reset-state outputs are the FETCH outputs with mem_ready=0.
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, J 000010, JAL 000011.
- Supported RTYPE functs: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Outputs not listed for a state are 0.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=001, alucontrol=010, pcsrc=00. irwrite and pcen equal mem_ready. Next state is DECODE on mem_ready, else stay.
- DECODE: alusrcb=011, alucontrol=010. Next state by opcode:
  - LW/SW → MEMADR
  - RTYPE with legal funct → RTYPEEX; RTYPE with illegal funct → TRAP
  - BEQ → BEQEX; BNE → BNEEX
  - ADDI/ANDI/ORI/SLTI → IMMEX
  - J → JEX; JAL → JALEX
  - any other opcode → TRAP
- MEMADR: alusrca=1, alusrcb=010, add. LW → MEMRD, SW → MEMWR.
- MEMRD: memreq=1, iord=1. Next state is MEMWB on mem_ready, else stay.
- MEMWB: regwrite=1, memtoreg=01, regdst=00. Next state FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Next state is FETCH on mem_ready, else stay.
- RTYPEEX: alusrca=1, alusrcb=000, alucontrol from funct. Next state RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00. Next state FETCH.
- BEQEX / BNEEX: alusrca=1, alusrcb=000, sub, pcsrc=01. pcen=zero for BEQ, pcen=~zero for BNE. Next state FETCH.
- IMMEX: alusrca=1.
  - ADDI: alusrcb=010, add.
  - SLTI: alusrcb=010, slt.
  - ANDI: alusrcb=100, and.
  - ORI: alusrcb=100, or.
  - Next state IMMWB.
- IMMWB: regwrite=1, regdst=00, memtoreg=00. Next state FETCH.
- JEX: pcen=1, pcsrc=10. Next state FETCH.
- JALEX: pcen=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10. The PC register already holds PC+4 at this point. Next state FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready=1.
  - Increments each cycle in those states while mem_ready=0.
  - If it would reach WAIT_LIMIT, next state is TRAP.
  - mem_ready in the same cycle as the limit wins: the access completes and no trap is raised.
- TRAP: every output 0, trap=1. The state is held until reset.
- mem_ready is ignored in states that do not assert memreq.

Optional Feature:
- Macro: MC_CONTROLLER_V2_PERF_EN.
- When defined:
  - cycles increments every clock out of reset.
  - retired increments on every transition into FETCH from a non-FETCH state.
  - Both counters wrap modulo 2^CNT_W and freeze in TRAP.
- When undefined: the retired and cycles ports are absent and no counter flops exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode and funct constants;
  - alucontrol, alusrcb, pcsrc, memtoreg and regdst encodings;
  - the aluop enum (ADD, SUB, FUNCT, IMM).
- Sub-module mc_aludec_v2: combinational mapping of aluop/funct/op to alucontrol, plus a funct_legal output used by DECODE.

Test Plan:
- Reset low mid-MEMRD (mem_ready=0) → state FETCH, memreq=1, iord=0, trap=0, counters=0 the same cycle.
- LW, memory answers after 3 wait cycles in both FETCH and MEMRD → irwrite/pcen pulse exactly once, regwrite with memtoreg=01 at cycle 10 after start.
- BNE with zero=0 → pcen=1, pcsrc=01 in BNEEX. BNE with zero=1 → pcen=0. BEQ shows the opposite.
- ORI then SLTI → alusrcb=100/alucontrol=001, then alusrcb=010/alucontrol=111. JAL → regdst=10, memtoreg=10, pcsrc=10, pcen=1.
- WAIT_LIMIT=4 with mem_ready held 0 in FETCH → trap=1 after 4 cycles. mem_ready=1 exactly on the 4th cycle → no trap, DECODE next.
- Opcode 111111 or RTYPE funct 000111 → TRAP after DECODE, all outputs 0, stays until reset. With PERF_EN, retired holds its value.
